// File: rtl/event_tx_scheduler_pkg.sv
// Shared types and constants for the event transmit scheduler.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package event_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_e;

    localparam logic [7:0] CH_F    = 8'h46;
    localparam logic [7:0] CH_N    = 8'h4E;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_ZERO = 8'h30;

    localparam int ID_W    = 6;
    localparam int ENTRY_W = ID_W + 1;

    // Queued event: is_fault = 1 for a fault, 0 for a node change.
    typedef struct packed {
        logic            is_fault;
        logic [ID_W-1:0] id;
    } entry_t;

    // Node id to {tens, ones} ASCII digits. An id of at most 63 needs at
    // most six subtractions of 10, so the loop unrolls into six
    // compare-subtract stages and no divider is built.
    function automatic logic [15:0] id_to_ascii(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] rem;
        logic [3:0]      tens;
        rem  = id;
        tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {CH_ZERO + {4'd0, tens}, CH_ZERO + {2'd0, rem}};
    endfunction

endpackage

// File: rtl/event_fifo_2w.sv
// Event queue with two write ports (wr0 has priority) and one read port.
// Latency: an entry written at an edge is readable in the next cycle.
// Backpressure: writes that do not fit are dropped and flagged on drop;
//               free space is judged before any same-cycle pop.
// Ports: wr0_vld/wr0_dat, wr1_vld/wr1_dat write; rd_vld/rd_rdy/rd_dat read;
//        level = entries held; drop = an offered write was discarded.
module event_fifo_2w
    import event_tx_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr0_vld,
    input  entry_t                 wr0_dat,
    input  logic                   wr1_vld,
    input  entry_t                 wr1_dat,
    input  logic                   rd_rdy,
    output logic                   rd_vld,
    output entry_t                 rd_dat,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   free;
    logic               acc0, acc1, pop;

    always_comb begin
        free = LVL_W'(DEPTH) - level_q;
        acc0 = wr0_vld && (free != '0);
        // wr1 lands behind wr0 when both are accepted, so it needs two slots.
        acc1 = wr1_vld && (acc0 ? (free >= LVL_W'(2)) : (free != '0));
        pop  = rd_rdy && (level_q != '0);

        mem_d = mem_q;
        if (acc0) mem_d[wr_ptr_q] = wr0_dat;
        if (acc1) mem_d[wr_ptr_q + PTR_W'(acc0)] = wr1_dat;

        wr_ptr_d = wr_ptr_q + PTR_W'(acc0) + PTR_W'(acc1);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(acc0) + LVL_W'(acc1) - LVL_W'(pop);
        drop     = (wr0_vld && !acc0) || (wr1_vld && !acc1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level_q gates what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_vld = (level_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign level  = level_q;

endmodule

// File: rtl/event_tx_scheduler.sv
// Queues fault/node events and sends each as a 4-byte ASCII message to the UART.
// Latency: pulse at t gives the first tx_start at t+3 when the UART is idle.
// Backpressure: holds each byte until tx_ready; a full queue drops events (sticky overflow).
// Ports: fault_detect/node_changed/node_counter event inputs; tx_ready/tx_start/
//        tx_data UART handshake; busy, msg_done, fifo_level, overflow status.
module event_tx_scheduler
    import event_tx_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fault_detect,
    input  logic                        node_changed,
    input  logic [5:0]                  node_counter,
    input  logic                        tx_ready,
    output logic                        tx_start,
    output logic [7:0]                  tx_data,
    output logic                        busy,
    output logic                        msg_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    entry_t             msg_q, msg_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               msg_done_q, msg_done_d;
    logic               overflow_q, overflow_d;

    entry_t             fault_ent, node_ent, fifo_dat;
    logic               fifo_vld, fifo_pop, fifo_drop;
    logic [15:0]        digits;
    logic [7:0]         cur_byte;

    always_comb begin
        fault_ent = '{is_fault: 1'b1, id: node_counter};
        node_ent  = '{is_fault: 1'b0, id: node_counter};
    end

    // Fault on the priority port so it survives when only one slot is free.
    event_fifo_2w #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr0_vld (fault_detect),
        .wr0_dat (fault_ent),
        .wr1_vld (node_changed),
        .wr1_dat (node_ent),
        .rd_rdy  (fifo_pop),
        .rd_vld  (fifo_vld),
        .rd_dat  (fifo_dat),
        .level   (fifo_level),
        .drop    (fifo_drop)
    );

    always_comb begin
        digits   = id_to_ascii(msg_q.id);
        cur_byte = CH_HASH;
        case (idx_q)
            2'd0:    cur_byte = msg_q.is_fault ? CH_F : CH_N;
            2'd1:    cur_byte = digits[15:8];
            2'd2:    cur_byte = digits[7:0];
            default: cur_byte = CH_HASH;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        msg_d      = msg_q;
        timer_d    = timer_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        msg_done_d = 1'b0;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | fifo_drop;

        case (state_q)
            ST_IDLE: begin
                if (fifo_vld) begin
                    fifo_pop = 1'b1;
                    msg_d    = fifo_dat;
                    idx_d    = 2'd0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    timer_d    = '0;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // The UART must acknowledge by dropping tx_ready; if it never
                // does, the same byte is offered again.
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT)) begin
                    state_d = ST_SEND;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    if (idx_q == 2'd3) begin
                        msg_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            msg_q      <= '0;
            timer_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            msg_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            msg_q      <= msg_d;
            timer_q    <= timer_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            msg_done_q <= msg_done_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign msg_done = msg_done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_event_tx_scheduler.sv
// Self-checking bench for event_tx_scheduler: table of single/dual events,
// plus hand-written overflow, timeout re-issue and mid-message reset sequences.
// Bytes seen on the UART are compared against a scoreboard queue.
module tb_event_tx_scheduler;

    typedef enum int {M_AUTO, M_HOLD0, M_HOLD1} uart_mode_e;

    typedef struct {
        logic        f;
        logic        n;
        logic [5:0]  id;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          n_msgs;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       fault_detect, node_changed;
    logic [5:0] node_counter;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy, msg_done, overflow;
    logic [2:0] fifo_level;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         nbytes = 0;
    int         pulse_cyc = 0;
    int         lat_cyc = 0;
    logic       lat_armed = 1'b0;
    uart_mode_e mode = M_AUTO;
    logic [7:0] sb [$];
    int         hold_cyc [$];
    logic [7:0] hold_dat [$];
    vec_t       vecs [7];

    event_tx_scheduler #(
        .FIFO_DEPTH   (4),
        .ACK_TIMEOUT  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fault_detect (fault_detect),
        .node_changed (node_changed),
        .node_counter (node_counter),
        .tx_ready     (tx_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .msg_done     (msg_done),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_msg(input logic f, input int id);
        logic [7:0] t, o;
        t = 8'(8'h30 + id / 10);
        o = 8'(8'h30 + id % 10);
        return {(f ? 8'h46 : 8'h4E), t, o, 8'h23};
    endfunction

    task automatic push_msg(input logic [31:0] m);
        sb.push_back(m[31:24]);
        sb.push_back(m[23:16]);
        sb.push_back(m[15:8]);
        sb.push_back(m[7:0]);
    endtask

    // Called at a negedge; returns at the negedge after the pulse cycle.
    task automatic drive_pulse(input logic f, input logic n, input logic [5:0] id);
        fault_detect = f;
        node_changed = n;
        node_counter = id;
        pulse_cyc    = cyc;
        lat_armed    = 1'b1;
        @(negedge clk);
        fault_detect = 1'b0;
        node_changed = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_cyc.delete();
        hold_dat.delete();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !busy && tx_ready && fifo_level == 3'd0) && n <= budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " completes in budget"}, 32'(n <= budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // UART model: acts on the negedge so DUT outputs are stable.
    initial begin
        int cnt;
        int rise_cyc;
        logic gap_armed;
        cnt       = 0;
        rise_cyc  = 0;
        gap_armed = 1'b0;
        tx_ready  = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                nbytes    = 0;
                gap_armed = 1'b0;
            end
            if (msg_done) done_cnt++;
            if (tx_start && lat_armed) begin
                lat_cyc   = cyc;
                lat_armed = 1'b0;
            end
            case (mode)
                M_HOLD0: begin
                    tx_ready = 1'b0;
                    check("no tx_start while tx_ready low", 32'(tx_start), 32'd0);
                end
                M_HOLD1: begin
                    tx_ready = 1'b1;
                    if (tx_start) begin
                        hold_cyc.push_back(cyc);
                        hold_dat.push_back(tx_data);
                    end
                end
                default: begin
                    if (tx_start) begin
                        check("tx_start only when tx_ready", 32'(tx_ready), 32'd1);
                        if (sb.size() == 0) begin
                            check("unexpected byte", 32'(tx_data), 32'hFFFF_FFFF);
                        end else begin
                            check("tx_data byte", 32'(tx_data), 32'(sb.pop_front()));
                        end
                        if (gap_armed) check("inter-byte gap", 32'(cyc - rise_cyc), 32'd2);
                        gap_armed = 1'b0;
                        nbytes++;
                        tx_ready = 1'b0;
                        cnt      = 10;
                    end else if (!tx_ready) begin
                        if (cnt <= 1) begin
                            tx_ready  = 1'b1;
                            rise_cyc  = cyc;
                            gap_armed = (nbytes % 4 != 0);
                        end else begin
                            cnt--;
                        end
                    end
                end
            endcase
        end
    end

    initial begin
        int d0;
        rst          = 1'b1;
        fault_detect = 1'b0;
        node_changed = 1'b0;
        node_counter = 6'd0;

        vecs[0] = '{1'b1, 1'b0, 6'd7,  32'h46303723, 32'h0,        1};
        vecs[1] = '{1'b1, 1'b1, 6'd42, 32'h46343223, 32'h4E343223, 2};
        vecs[2] = '{1'b0, 1'b1, 6'd0,  32'h4E303023, 32'h0,        1};
        vecs[3] = '{1'b0, 1'b1, 6'd63, 32'h4E363323, 32'h0,        1};
        vecs[4] = '{1'b1, 1'b0, 6'd10, 32'h46313023, 32'h0,        1};
        vecs[5] = '{1'b1, 1'b0, 6'd59, 32'h46353923, 32'h0,        1};
        vecs[6] = '{1'b0, 1'b1, 6'd19, 32'h4E313923, 32'h0,        1};

        repeat (3) @(negedge clk);
        check("reset tx_start",   32'(tx_start),   32'd0);
        check("reset tx_data",    32'(tx_data),    32'h00);
        check("reset busy",       32'(busy),       32'd0);
        check("reset msg_done",   32'(msg_done),   32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        check("reset overflow",   32'(overflow),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: single and dual events, one at a time.
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            push_msg(vecs[i].exp_a);
            if (vecs[i].n_msgs == 2) push_msg(vecs[i].exp_b);
            drive_pulse(vecs[i].f, vecs[i].n, vecs[i].id);
            wait_idle(200, "table vector");
            check("first tx_start latency", 32'(lat_cyc - pulse_cyc), 32'd3);
            check("msg_done count",         32'(done_cnt - d0), 32'(vecs[i].n_msgs));
            check("fifo_level drained",     32'(fifo_level), 32'd0);
            check("no overflow",            32'(overflow), 32'd0);
        end

        // Queue fills while the UART is held busy; sixth event is dropped.
        mode = M_HOLD0;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) push_msg(exp_msg(i % 2 == 0, 1 + 11 * i));
            drive_pulse(i % 2 == 0, i % 2 != 0, 6'(1 + 11 * i));
            if (i == 4) begin
                check("level after 5 events",    32'(fifo_level), 32'd4);
                check("no overflow before drop", 32'(overflow),   32'd0);
            end
            if (i < 5) repeat (2) @(negedge clk);
        end
        check("level when full",  32'(fifo_level), 32'd4);
        check("overflow on drop", 32'(overflow),   32'd1);
        check("busy while held",  32'(busy),       32'd1);
        mode = M_AUTO;
        wait_idle(900, "backlog");
        check("backlog msg_done count", 32'(done_cnt - d0), 32'd5);
        check("overflow sticky",        32'(overflow), 32'd1);

        // One free slot, fault and node together: fault kept, node dropped.
        do_reset();
        check("overflow cleared by reset", 32'(overflow), 32'd0);
        mode = M_HOLD0;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        push_msg(exp_msg(1'b0, 20)); drive_pulse(1'b0, 1'b1, 6'd20); repeat (2) @(negedge clk);
        push_msg(exp_msg(1'b1, 21)); drive_pulse(1'b1, 1'b0, 6'd21); repeat (2) @(negedge clk);
        push_msg(exp_msg(1'b0, 22)); drive_pulse(1'b0, 1'b1, 6'd22); repeat (2) @(negedge clk);
        push_msg(exp_msg(1'b1, 23)); drive_pulse(1'b1, 1'b0, 6'd23);
        check("three queued", 32'(fifo_level), 32'd3);
        push_msg(32'h46363323);
        drive_pulse(1'b1, 1'b1, 6'd63);
        check("fault kept, level full", 32'(fifo_level), 32'd4);
        check("node dropped overflow",  32'(overflow),   32'd1);
        mode = M_AUTO;
        wait_idle(900, "partial drop");
        check("partial drop msg_done count", 32'(done_cnt - d0), 32'd5);

        // UART never acknowledges: same byte re-offered every ACK_TIMEOUT+2.
        do_reset();
        mode = M_HOLD1;
        d0 = done_cnt;
        drive_pulse(1'b1, 1'b0, 6'd33);
        for (int n = 0; n < 150 && hold_cyc.size() < 4; n++) @(negedge clk);
        check("re-issue count", 32'(hold_cyc.size() >= 4), 32'd1);
        if (hold_cyc.size() >= 4) begin
            check("first start latency", 32'(hold_cyc[0] - pulse_cyc), 32'd3);
            for (int k = 0; k < 4; k++) begin
                check("re-issued byte unchanged", 32'(hold_dat[k]), 32'h46);
                if (k > 0) check("re-issue period", 32'(hold_cyc[k] - hold_cyc[k-1]), 32'd18);
            end
        end
        check("no msg_done without ack", 32'(done_cnt - d0), 32'd0);
        check("busy during retries",     32'(busy), 32'd1);
        do_reset();
        mode = M_AUTO;
        repeat (2) @(negedge clk);

        // Reset after the second byte of "N63#"; the pulse during reset is ignored.
        sb.push_back(8'h4E);
        sb.push_back(8'h36);
        drive_pulse(1'b0, 1'b1, 6'd63);
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        check("partial bytes sent", 32'(sb.size()), 32'd0);
        rst          = 1'b1;
        fault_detect = 1'b1;
        node_counter = 6'd9;
        @(negedge clk);
        check("mid-msg reset tx_start",   32'(tx_start),   32'd0);
        check("mid-msg reset busy",       32'(busy),       32'd0);
        check("mid-msg reset fifo_level", 32'(fifo_level), 32'd0);
        check("mid-msg reset tx_data",    32'(tx_data),    32'h00);
        rst          = 1'b0;
        fault_detect = 1'b0;
        repeat (3) @(negedge clk);
        check("pulse in reset ignored", 32'({busy, fifo_level}), 32'd0);
        wait_idle(100, "uart settle");
        d0 = done_cnt;
        push_msg(32'h4E303523);
        drive_pulse(1'b0, 1'b1, 6'd5);
        wait_idle(200, "after reset");
        check("after reset msg_done count", 32'(done_cnt - d0), 32'd1);
        check("after reset level",          32'(fifo_level),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_tx_scheduler.md
# event_tx_scheduler

Consumes the single-cycle `fault_detect` / `node_changed` pulses and the 6-bit `node_counter` from the change-detection stage. Queues them in a small two-write-port FIFO. Serialises each event as a 4-byte ASCII message over the shared UART transmitter using a start/ready handshake. Sits between change detection and the UART TX, and is the only block allowed to drive the transmitter.

## Interface
- `FIFO_DEPTH`, 4: event queue depth; power of two, ≥2.
- `ACK_TIMEOUT`, 16: cycles to wait for the transmitter to drop `tx_ready` after `tx_start` before re-issuing the byte.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `fault_detect`  in  1  one-cycle pulse: fault event.
- `node_changed`  in  1  one-cycle pulse: node event.
- `node_counter`  in  6  node id, sampled in the same cycle as the pulse.
- `tx_ready`  in  1  UART idle; low while a byte is shifting.
- `tx_start`  out  1  one-cycle registered pulse: transmit `tx_data`.
- `tx_data`  out  8  byte to send; held stable from `tx_start` until the byte completes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `msg_done`  out  1  one-cycle pulse after the 4th byte of a message completes.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries queued.
- `overflow`  out  1  sticky; an event was dropped; cleared only by `rst`.

## Operation
- FIFO entry format: {type, id[5:0]}, with type 1 = fault, 0 = node.
- Event arrival:
  - A pulse in cycle t writes its entry at the t→t+1 edge.
  - Both pulses in one cycle: the fault entry is written first (slot `wr_ptr`), then the node entry (slot `wr_ptr+1`). Both carry the same id.
  - Room for only one entry: the fault is kept, the node is dropped, and `overflow` is set.
  - FIFO full: every arriving event is dropped and `overflow` is set.
  - A pop and a write in the same cycle are both honoured; `fifo_level` reflects the net change.
- Message format, byte index 0..3:
  - type char: 'F' = 0x46 or 'N' = 0x4E;
  - tens digit, 0x30 + id/10;
  - ones digit, 0x30 + id%10;
  - '#' = 0x23.
  - id ≤ 63, so two digits always suffice.
- State machine:
  - IDLE: if FIFO is non-empty, pop into the message register, set idx = 0, go to SEND.
  - SEND: when `tx_ready` = 1, register `tx_start` = 1 and `tx_data` = byte[idx]; go to WAIT_BUSY with the timer cleared.
  - WAIT_BUSY: if `tx_ready` = 0, go to WAIT_DONE. Otherwise increment the timer; when it reaches `ACK_TIMEOUT`, go to SEND and re-issue the same idx.
  - WAIT_DONE: when `tx_ready` = 1:
    - if idx = 3, pulse `msg_done` and go to IDLE;
    - otherwise idx++ and go to SEND.
- Reset (including mid-message):
  - state goes to IDLE; FIFO pointers and level go to 0; the partial message is abandoned and never resumed.
  - Output values: `tx_start` = 0, `tx_data` = 0x00, `busy` = 0, `msg_done` = 0, `fifo_level` = 0, `overflow` = 0.
  - Pulses arriving during reset are ignored.

## Timing
- Pulse at cycle t: entry visible at t+1, popped at t+1 (IDLE), SEND at t+2. With `tx_ready` = 1, `tx_start` is high at t+3.
- `tx_start` is never high in two consecutive cycles.
- Between bytes: `tx_ready` rising in cycle u gives the next `tx_start` at u+2 (WAIT_DONE → SEND → registered start).
- After `msg_done`, the next message's first `tx_start` comes at ≥3 cycles if the FIFO is non-empty.
- Timeout re-issue: `tx_start` repeats every `ACK_TIMEOUT`+2 cycles while `tx_ready` stays high.

## Structure
- Shared package:
  - state enum (IDLE, SEND, WAIT_BUSY, WAIT_DONE);
  - ASCII constants `CH_F`, `CH_N`, `CH_HASH`, `CH_ZERO`;
  - entry struct/width localparam.
- Sub-module `event_fifo_2w`: dual-write/single-read FIFO with level and drop flag.
- id → two ASCII digits is a combinational function in the package (compare-subtract by 10, max 6 iterations).

## Test plan
- `fault_detect` with `node_counter` = 7, `tx_ready` modelled as 10-cycle busy: bytes 0x46, 0x30, 0x37, 0x23 in order; one `msg_done`; `fifo_level` returns to 0.
- `fault_detect` and `node_changed` together, id = 42: "F42#" (0x46 0x34 0x32 0x23), then "N42#" (0x4E 0x34 0x32 0x23); `overflow` = 0.
- `tx_ready` held 0, six single pulses 3 cycles apart: first popped, four queued, sixth dropped → `fifo_level` = 4, `overflow` = 1. Release `tx_ready`: five complete messages.
- `tx_ready` held 1 (no ack): `tx_start` re-issued with identical `tx_data` every 18 cycles at `ACK_TIMEOUT` = 16; idx never advances.
- `rst` asserted after byte 1 of "N63#": next cycle `tx_start` = 0, `busy` = 0, `fifo_level` = 0. A new node pulse with id 5 then yields the complete "N05#".
- Node pulse at id 63 with 3 entries queued plus a simultaneous fault: fault stored, node dropped, `overflow` = 1, `fifo_level` = 4.
